drum_seq_control: RTL and testbench

- Sequencing controller for the four-instrument drum-pattern datapath.
- Steps the user through loading patterns 1-4 and the BPM from the shared 8-bit select bus, one go press per item.
- Then runs playback: drives play and an 8-step timing index at a rate derived from the captured BPM.
- Sits between the board keys/switches and the datapath; owns every ld_* strobe and the step clock.

---
 rtl/drum_pkg.sv | 16 +
 rtl/beat_tick_gen.sv | 50 +++++
 rtl/drum_seq_control.sv | 139 +++++++++++++
 tb/tb_drum_seq_control.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared definitions for the drum-pattern sequencing controller:
// FSM state encoding (also shown on the debug LEDs) and the step-index width.
package drum_pkg;

   localparam int TIMING_W      = 4;
   localparam int STEPS_DEFAULT = 8;

   localparam logic [2:0] S_INS1  = 3'd0;
   localparam logic [2:0] S_INS2  = 3'd1;
   localparam logic [2:0] S_INS3  = 3'd2;
   localparam logic [2:0] S_INS4  = 3'd3;
   localparam logic [2:0] S_BPM   = 3'd4;
   localparam logic [2:0] S_PLAY  = 3'd5;
   localparam logic [2:0] S_PAUSE = 3'd6;

endpackage

// File: rtl/beat_tick_gen.sv
// Step-rate divider: while enabled, emits a one-cycle tick every
// (256 - bpm) * TICK_BASE clock cycles. The count is held while disabled.
module beat_tick_gen
   import drum_pkg::*;
#(
   parameter int TICK_BASE = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear,
   input  logic [7:0] bpm,
   output logic       tick
);

   // One extra bit so that a full 256 * TICK_BASE period never wraps.
   localparam int               CNT_W = 8 + $clog2(TICK_BASE) + 1;
   localparam logic [CNT_W-1:0] BASE  = CNT_W'(TICK_BASE);

   logic [CNT_W-1:0] units;
   logic [CNT_W-1:0] period_m1;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // The period depends only on bpm, so it changes only when bpm does.
   always_comb begin
      units     = CNT_W'(9'd256 - {1'b0, bpm});
      period_m1 = (units * BASE) - CNT_W'(1);
   end

   assign tick = enable & (count_q == period_m1);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = tick ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/drum_seq_control.sv
// Sequencing controller for the four-instrument drum datapath: walks the user
// through loading four patterns and the BPM, then runs and pauses playback.
module drum_seq_control
   import drum_pkg::*;
#(
   parameter int STEPS     = STEPS_DEFAULT,
   parameter int TICK_BASE = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                go,
   input  logic                stop,
   input  logic [7:0]          sel,
   output logic                ld_ins1,
   output logic                ld_ins2,
   output logic                ld_ins3,
   output logic                ld_ins4,
   output logic                ld_bpm,
   output logic                play,
   output logic [TIMING_W-1:0] timing,
   output logic [7:0]          bpm,
   output logic [2:0]          state_dbg
);

   logic                go_q;
   logic                stop_q;
   logic                go_e;
   logic                stop_e;
   logic                adv;
   logic                load_bpm;
   logic                tick;
   logic [2:0]          state_q;
   logic [2:0]          state_d;
   logic [4:0]          ld_q;
   logic [4:0]          ld_d;
   logic                play_q;
   logic                play_d;
   logic [TIMING_W-1:0] timing_q;
   logic [TIMING_W-1:0] timing_d;
   logic [7:0]          bpm_q;
   logic [7:0]          bpm_d;

   // A held key yields a single event; stop overrides a coincident go.
   assign go_e     = go & ~go_q;
   assign stop_e   = stop & ~stop_q;
   assign adv      = go_e & ~stop_e;
   assign load_bpm = adv & (state_q == S_BPM);

   beat_tick_gen #(
      .TICK_BASE (TICK_BASE)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (play_q),
      .clear  (stop_e | load_bpm),
      .bpm    (bpm_q),
      .tick   (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_INS1;
         go_q    <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go;
         stop_q  <= stop;
      end
   end

   always_comb begin
      state_d = (state_q > S_PAUSE) ? S_INS1 : state_q;
      if (stop_e) begin
         state_d = S_INS1;
      end else if (go_e) begin
         case (state_q)
            S_INS1:  state_d = S_INS2;
            S_INS2:  state_d = S_INS3;
            S_INS3:  state_d = S_INS4;
            S_INS4:  state_d = S_BPM;
            S_BPM:   state_d = S_PLAY;
            S_PLAY:  state_d = S_PAUSE;
            S_PAUSE: state_d = S_PLAY;
            default: state_d = S_INS1;
         endcase
      end
   end

   always_comb begin
      ld_d = '0;
      if (adv) begin
         case (state_q)
            S_INS1:  ld_d = 5'b00001;
            S_INS2:  ld_d = 5'b00010;
            S_INS3:  ld_d = 5'b00100;
            S_INS4:  ld_d = 5'b01000;
            S_BPM:   ld_d = 5'b10000;
            default: ld_d = '0;
         endcase
      end
      bpm_d  = load_bpm ? sel : bpm_q;
      play_d = (state_d == S_PLAY);
      // A tick coinciding with a pause still advances the step before it is held.
      timing_d = timing_q;
      if (stop_e) begin
         timing_d = '0;
      end else if (load_bpm) begin
         timing_d = TIMING_W'(1);
      end else if (tick) begin
         timing_d = (timing_q == TIMING_W'(STEPS)) ? TIMING_W'(1) : timing_q + TIMING_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_q     <= '0;
         play_q   <= 1'b0;
         timing_q <= '0;
         bpm_q    <= '0;
      end else begin
         ld_q     <= ld_d;
         play_q   <= play_d;
         timing_q <= timing_d;
         bpm_q    <= bpm_d;
      end
   end

   assign ld_ins1   = ld_q[0];
   assign ld_ins2   = ld_q[1];
   assign ld_ins3   = ld_q[2];
   assign ld_ins4   = ld_q[3];
   assign ld_bpm    = ld_q[4];
   assign play      = play_q;
   assign timing    = timing_q;
   assign bpm       = bpm_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_drum_seq_control.sv
// Scoreboard bench for drum_seq_control with TICK_BASE=4, STEPS=8: a cycle
// model predicts every output, a negedge monitor compares, plus directed checks.
module tb_drum_seq_control;

   localparam int TB_BASE  = 4;
   localparam int TB_STEPS = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       go    = 1'b0;
   logic       stop  = 1'b0;
   logic [7:0] sel   = 8'h00;
   logic       ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm, play;
   logic [3:0] timing;
   logic [7:0] bpm;
   logic [2:0] state_dbg;

   drum_seq_control #(
      .STEPS     (TB_STEPS),
      .TICK_BASE (TB_BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .stop      (stop),
      .sel       (sel),
      .ld_ins1   (ld_ins1),
      .ld_ins2   (ld_ins2),
      .ld_ins3   (ld_ins3),
      .ld_ins4   (ld_ins4),
      .ld_bpm    (ld_bpm),
      .play      (play),
      .timing    (timing),
      .bpm       (bpm),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] ld;
      logic       play;
      logic [3:0] timing;
      logic [7:0] bpm;
      logic [2:0] st;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0..3 = loading pattern N+1, 4 = BPM, 5 = playing,
   // 6 = paused. The step is derived from total cycles spent playing.
   int m_mode   = 0;
   int m_bpm    = 0;
   int m_played = 0;
   bit m_pgo    = 1'b0;
   bit m_pstop  = 1'b0;

   function automatic int m_step();
      int period;
      period = (256 - m_bpm) * TB_BASE;
      return (m_played / period) % TB_STEPS + 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode   = 0;
         m_bpm    = 0;
         m_played = 0;
         m_pgo    = 1'b0;
         m_pstop  = 1'b0;
         exp_q.delete();
      end else begin
         obs_t e;
         bit   ge;
         bit   se;
         ge      = go && !m_pgo;
         se      = stop && !m_pstop;
         m_pgo   = go;
         m_pstop = stop;
         e.ld    = 5'b0;
         if (se) begin
            m_mode   = 0;
            m_played = 0;
         end else if (ge) begin
            if (m_mode <= 4) begin
               e.ld = 5'(1 << m_mode);
               if (m_mode == 4) begin
                  m_bpm    = int'(sel);
                  m_played = 0;
               end
               m_mode++;
            end else if (m_mode == 5) begin
               m_played++;
               m_mode = 6;
            end else begin
               m_mode = 5;
            end
         end else if (m_mode == 5) begin
            m_played++;
         end
         e.play   = (m_mode == 5);
         e.timing = (m_mode >= 5) ? 4'(m_step()) : 4'd0;
         e.bpm    = 8'(m_bpm);
         e.st     = 3'(m_mode);
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (!reset && exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front();
         check("ld_strobes", int'({ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1}), int'(e.ld));
         check("play", int'(play), int'(e.play));
         check("timing", int'(timing), int'(e.timing));
         check("bpm", int'(bpm), int'(e.bpm));
         check("state_dbg", int'(state_dbg), int'(e.st));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int hold);
      go = 1'b1;
      cyc(hold);
      go = 1'b0;
      cyc(3);
   endtask

   task automatic load_all(input logic [7:0] b);
      for (int i = 0; i < 4; i++) begin
         sel = 8'($urandom);
         press(10);
      end
      sel = b;
      press(10);
   endtask

   task automatic wait_timing(input int val, input int budget);
      int n;
      n = 0;
      while (int'(timing) != val && n < budget) begin
         cyc(1);
         n++;
      end
      check("wait_timing", int'(timing), val);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ld"}, int'({ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1}), 0);
      check({tag, "_play"}, int'(play), 0);
      check({tag, "_timing"}, int'(timing), 0);
      check({tag, "_bpm"}, int'(bpm), 0);
      check({tag, "_state"}, int'(state_dbg), 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      cyc(3);
      check_all_zero("reset_init");
      reset = 1'b0;
      cyc(2);

      // Partial load, then an asynchronous reset between clock edges.
      sel = 8'($urandom);
      press(10);
      sel = 8'($urandom);
      press(10);
      check("pre_reset_state", int'(state_dbg), 2);
      #2 reset = 1'b1;
      #1 check_all_zero("reset_async");
      @(negedge clk);
      reset = 1'b0;
      cyc(2);

      // Full load sequence and playback at bpm 252 (period 16).
      sel = 8'hA5; press(10);
      sel = 8'h0F; press(10);
      sel = 8'hF0; press(10);
      sel = 8'h81; press(10);
      sel = 8'd252; press(10);
      check("loaded_bpm", int'(bpm), 252);
      check("loaded_play", int'(play), 1);
      cyc(16 * 9);

      // Pause five cycles into step 3, hold, then resume.
      wait_timing(3, 200);
      cyc(4);
      go = 1'b1;
      cyc(3);
      go = 1'b0;
      cyc(100);
      check("paused_timing", int'(timing), 3);
      check("paused_play", int'(play), 0);
      check("paused_state", int'(state_dbg), 6);
      go = 1'b1;
      n  = 0;
      while (int'(timing) != 4 && n < 50) begin
         cyc(1);
         n++;
      end
      check("resume_latency", n, 12);
      go = 1'b0;
      cyc(40);

      // Simultaneous go and stop: stop wins.
      go   = 1'b1;
      stop = 1'b1;
      cyc(2);
      go   = 1'b0;
      stop = 1'b0;
      cyc(1);
      check("stop_state", int'(state_dbg), 0);
      check("stop_timing", int'(timing), 0);
      check("stop_play", int'(play), 0);
      check("stop_bpm", int'(bpm), 252);
      cyc(3);

      // Fastest rate: bpm 255 gives a 4-cycle step.
      load_all(8'd255);
      wait_timing(2, 50);
      n = 0;
      while (int'(timing) != 3 && n < 50) begin
         cyc(1);
         n++;
      end
      check("period_255", n, 4);
      cyc(30);

      // Asynchronous reset during playback.
      #2 reset = 1'b1;
      #1 check_all_zero("reset_play");
      @(negedge clk);
      reset = 1'b0;
      cyc(2);

      // Slowest rate: bpm 0 gives a 1024-cycle step; a long go press pauses once.
      load_all(8'd0);
      cyc(1100);
      press(50);
      check("long_go_state", int'(state_dbg), 6);
      press(10);
      wait_timing(3, 3000);
      cyc(20);
      stop = 1'b1;
      cyc(2);
      stop = 1'b0;
      cyc(2);

      // Randomised key activity.
      for (int i = 0; i < 4000; i++) begin
         sel = 8'($urandom_range(200, 255));
         if ($urandom_range(0, 15) == 0) go = ~go;
         if ($urandom_range(0, 299) == 0) stop = 1'b1;
         else if ($urandom_range(0, 3) == 0) stop = 1'b0;
         cyc(1);
      end
      go   = 1'b0;
      stop = 1'b0;
      cyc(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
